// File: rtl/esc_pkg.sv
// rtl/esc_pkg.sv - shared defaults and saturating compensation helper for the multi-channel ESC interface
//
// Contents:
//   DEF_* localparams : default channel count, field widths, frame width, idle pulse, scale
//   sat_comp()        : speed + offset, clipped to the largest value a speed field can hold
package esc_pkg;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_SPEED_W   = 11;
  localparam int DEF_OFF_W     = 10;
  localparam int DEF_PERIOD_W  = 20;
  localparam int DEF_MIN_PULSE = 50000;
  localparam int DEF_SCALE     = 3;

  // Callers zero-extend their fields to 32 bits. Widths are small enough
  // that the sum cannot wrap at 32 bits.
  function automatic logic [31:0] sat_comp(input logic [31:0] spd,
                                           input logic [31:0] ofs,
                                           input int unsigned speed_w);
    logic [31:0] sum;
    logic [31:0] lim;
    sum = spd + ofs;
    lim = (32'd1 << speed_w) - 32'd1;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/esc_channel.sv
// rtl/esc_channel.sv - one ESC channel: staging, pulse calculation, frame-aligned active width, pwm flop
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   speed, off     : this channel's slice of the packed setting buses
//   wr             : capture speed/off into staging
//   armed          : arm request, sampled only at the frame boundary
//   cnt            : shared frame counter
//   boundary       : high in the last cycle of a frame (cnt all ones)
//   pwm            : registered pulse output
module esc_channel
  import esc_pkg::*;
#(
  parameter int SPEED_W   = DEF_SPEED_W,
  parameter int OFF_W     = DEF_OFF_W,
  parameter int PERIOD_W  = DEF_PERIOD_W,
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int SCALE     = DEF_SCALE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SPEED_W-1:0]  speed,
  input  logic [OFF_W-1:0]    off,
  input  logic                wr,
  input  logic                armed,
  input  logic [PERIOD_W-1:0] cnt,
  input  logic                boundary,
  output logic                pwm
);

  localparam logic [PERIOD_W-1:0] IDLE_PULSE = PERIOD_W'(MIN_PULSE);
  localparam logic [PERIOD_W-1:0] SCALE_P    = PERIOD_W'(SCALE);

  logic [SPEED_W-1:0]  stg_speed;
  logic [OFF_W-1:0]    stg_off;
  logic [SPEED_W-1:0]  src_speed;
  logic [OFF_W-1:0]    src_off;
  logic [PERIOD_W-1:0] comp;
  logic [PERIOD_W-1:0] pulse_calc;
  logic [PERIOD_W-1:0] active_pulse;
  logic                active_armed;

  // A write landing in the boundary cycle must still make the next frame,
  // so the pulse is computed from the incoming data rather than staging.
  assign src_speed  = wr ? speed : stg_speed;
  assign src_off    = wr ? off   : stg_off;
  assign comp       = PERIOD_W'(sat_comp(32'(src_speed), 32'(src_off), SPEED_W));
  assign pulse_calc = comp * SCALE_P + IDLE_PULSE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_speed    <= '0;
      stg_off      <= '0;
      active_pulse <= IDLE_PULSE;
      active_armed <= 1'b0;
      pwm          <= 1'b0;
    end else begin
      if (wr) begin
        stg_speed <= speed;
        stg_off   <= off;
      end
      if (boundary) begin
        active_armed <= armed;
        active_pulse <= armed ? pulse_calc : IDLE_PULSE;
      end
      // Disarmed channels still emit the idle pulse so the ESC stays calibrated.
      pwm <= (cnt < (active_armed ? active_pulse : IDLE_PULSE));
    end
  end

endmodule

// File: rtl/esc_interface_multi.sv
// rtl/esc_interface_multi.sv - multi-channel ESC PWM interface sharing one frame counter
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   speed        : NUM_CH packed unsigned speeds, channel 0 in LSBs
//   off          : NUM_CH packed unsigned trim offsets, channel 0 in LSBs
//   wr           : capture all speed/off fields into staging
//   armed        : 0 forces every channel to MIN_PULSE from the next frame
//   pwm          : registered PWM per channel
//   frame_start  : one-clk pulse aligned with the pwm rising edge
module esc_interface_multi
  import esc_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int SPEED_W   = DEF_SPEED_W,
  parameter int OFF_W     = DEF_OFF_W,
  parameter int PERIOD_W  = DEF_PERIOD_W,
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int SCALE     = DEF_SCALE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*SPEED_W-1:0] speed,
  input  logic [NUM_CH*OFF_W-1:0]   off,
  input  logic                      wr,
  input  logic                      armed,
  output logic [NUM_CH-1:0]         pwm,
  output logic                      frame_start
);

  localparam longint MAX_PULSE  = (longint'(2) ** SPEED_W - 1) * SCALE + MIN_PULSE;
  localparam longint FRAME_CLKS = longint'(2) ** PERIOD_W;

  // The widest pulse must fit in a frame, otherwise the counter compare wraps.
  if (MAX_PULSE > FRAME_CLKS - 1) begin : g_range_err
    $error("esc_interface_multi: maximum pulse does not fit in PERIOD_W bits");
  end
  if (OFF_W > SPEED_W) begin : g_off_err
    $error("esc_interface_multi: OFF_W must not exceed SPEED_W");
  end

  logic [PERIOD_W-1:0] cnt;
  logic                boundary;

  assign boundary = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt + 1'b1;
      frame_start <= (cnt == '0);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    esc_channel #(
      .SPEED_W   (SPEED_W),
      .OFF_W     (OFF_W),
      .PERIOD_W  (PERIOD_W),
      .MIN_PULSE (MIN_PULSE),
      .SCALE     (SCALE)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .speed    (speed[i*SPEED_W +: SPEED_W]),
      .off      (off[i*OFF_W +: OFF_W]),
      .wr       (wr),
      .armed    (armed),
      .cnt      (cnt),
      .boundary (boundary),
      .pwm      (pwm[i])
    );
  end

endmodule

// File: tb/tb_esc_interface_multi.sv
// tb/tb_esc_interface_multi.sv - scoreboard bench for esc_interface_multi on a shortened frame
module tb_esc_interface_multi;

  localparam int NUM_CH    = 4;
  localparam int SPEED_W   = 9;
  localparam int OFF_W     = 8;
  localparam int PERIOD_W  = 11;
  localparam int MIN_PULSE = 500;
  localparam int SCALE     = 3;
  localparam int FRAME     = 2048;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_CH*SPEED_W-1:0] speed = '0;
  logic [NUM_CH*OFF_W-1:0]   off = '0;
  logic                      wr = 1'b0;
  logic                      armed = 1'b0;
  logic [NUM_CH-1:0]         pwm;
  logic                      frame_start;

  esc_interface_multi #(
    .NUM_CH    (NUM_CH),
    .SPEED_W   (SPEED_W),
    .OFF_W     (OFF_W),
    .PERIOD_W  (PERIOD_W),
    .MIN_PULSE (MIN_PULSE),
    .SCALE     (SCALE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .speed       (speed),
    .off         (off),
    .wr          (wr),
    .armed       (armed),
    .pwm         (pwm),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q [NUM_CH][$];

  // Posedges since reset release; the next posedge sees cnt == cyc % FRAME.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_all(input int w0, input int w1, input int w2, input int w3);
    exp_q[0].push_back(w0);
    exp_q[1].push_back(w1);
    exp_q[2].push_back(w2);
    exp_q[3].push_back(w3);
  endtask

  // Lands on the negedge whose following posedge samples cnt == c in frame f.
  task automatic goto(input int f, input int c);
    int target;
    int guard;
    target = f * FRAME + c;
    guard  = 0;
    while (cyc != target && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL goto_timeout: cyc %0d, expected %0d", cyc, target);
    end
  endtask

  task automatic do_wr(input logic [SPEED_W-1:0] s0, input logic [SPEED_W-1:0] s1,
                       input logic [SPEED_W-1:0] s2, input logic [SPEED_W-1:0] s3,
                       input logic [OFF_W-1:0] o0, input logic [OFF_W-1:0] o1,
                       input logic [OFF_W-1:0] o2, input logic [OFF_W-1:0] o3);
    speed = {s3, s2, s1, s0};
    off   = {o3, o2, o1, o0};
    wr    = 1'b1;
    @(negedge clk);
    wr    = 1'b0;
  endtask

  // Monitor: measures each high pulse and checks it against the scoreboard,
  // plus rising-edge alignment across channels, frame_start and frame period.
  logic [NUM_CH-1:0] prev = '0;
  int                width [NUM_CH];
  longint            tcyc = 0;
  longint            last_rise = 0;
  bit                have_rise = 0;

  always @(negedge clk) begin
    logic [NUM_CH-1:0] rise;
    int e;
    tcyc++;
    if (!rst_n) begin
      prev      = '0;
      have_rise = 0;
      for (int i = 0; i < NUM_CH; i++) width[i] = 0;
    end else begin
      rise = pwm & ~prev;
      if (rise != '0 || frame_start) begin
        check("rise_aligned", rise, 4'hF);
        check("frame_start_at_rise", frame_start, 1);
        if (have_rise) check("frame_period", tcyc - last_rise, FRAME);
        last_rise = tcyc;
        have_rise = 1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (pwm[i]) begin
          width[i] = prev[i] ? width[i] + 1 : 1;
        end else if (prev[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_pulse_ch%0d", i), width[i], -1);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("width_ch%0d", i), width[i], e);
          end
        end
      end
      prev = pwm;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_pwm", pwm, 0);
    check("reset_frame_start", frame_start, 0);
    push_all(500, 500, 500, 500);
    #1 rst_n = 1'b1;

    // Basic armed pulse: 192*3+500
    goto(0, 100);
    armed = 1'b1;
    do_wr(128, 0, 0, 0, 64, 0, 0, 0);
    push_all(1076, 500, 500, 500);

    // Saturation: 500+200 clips to 511
    goto(1, 100);
    do_wr(500, 0, 0, 0, 200, 0, 0, 0);
    push_all(2033, 500, 500, 500);

    // Mid-frame write while ch0 is still high; applies next frame only
    goto(2, 1500);
    do_wr(511, 100, 0, 0, 0, 0, 0, 0);
    push_all(2033, 800, 500, 500);

    // Write in the boundary cycle goes active immediately
    goto(3, 2047);
    do_wr(0, 10, 0, 0, 0, 5, 0, 0);
    push_all(500, 545, 500, 500);

    goto(4, 200);
    do_wr(50, 60, 70, 80, 0, 0, 0, 0);
    push_all(650, 680, 710, 740);

    // Disarm mid-frame: current frame untouched, next frame idle
    goto(5, 300);
    armed = 1'b0;
    push_all(500, 500, 500, 500);

    // Re-arm restores the staged widths
    goto(6, 300);
    armed = 1'b1;
    push_all(650, 680, 710, 740);

    // A disarm glitch that is gone before the boundary has no effect
    goto(7, 100);
    armed = 1'b0;
    goto(7, 200);
    armed = 1'b1;
    push_all(650, 680, 710, 740);

    // Independent channels
    goto(8, 100);
    do_wr(0, 100, 341, 511, 0, 0, 0, 0);
    push_all(500, 800, 1523, 2033);

    // Offset field at full scale, alone and with saturation
    goto(9, 100);
    do_wr(511, 511, 0, 0, 255, 0, 255, 0);
    push_all(2033, 2033, 1265, 500);

    // Asynchronous reset in the middle of the pulses
    goto(10, 1000);
    check("pre_reset_pwm", pwm, 4'b0111);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_pwm", pwm, 0);
    check("async_reset_frame_start", frame_start, 0);
    for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
    repeat (3) @(negedge clk);
    push_all(500, 500, 500, 500);
    #1 rst_n = 1'b1;

    // Still idle after release: staging cleared, no write yet
    goto(0, 100);
    push_all(500, 500, 500, 500);

    goto(1, 100);
    do_wr(20, 0, 0, 0, 0, 0, 0, 0);
    push_all(560, 500, 500, 500);

    goto(2, 2040);
    for (int i = 0; i < NUM_CH; i++)
      check($sformatf("queue_empty_ch%0d", i), exp_q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
